// File: rtl/dac_spi_responder.sv
// SPI responder (slave end) of the DAC serial link: receives WIDTH-bit words MSB first
// and shifts a response out on dac_miso. Define DAC_SPI_RESPONDER_LOOPBACK_EN to echo the last received word.
module dac_spi_responder #(
  parameter int WIDTH = 8
) (
  input  logic             sclk,
  input  logic             n_reset,
  input  logic             dac_cs,
  input  logic             dac_mosi,
  output logic             dac_miso,
  input  logic [WIDTH-1:0] tx_data,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy,
  output logic [1:0]       o_dbg_state
);

  // Handshake: none; a frame is every run of rising sclk edges with dac_cs low, rx_valid
  // and frame_err are single-cycle pulses, overrun is a level cleared by the next cs-high edge.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(WIDTH);

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_rx_sh, w_rx_sh_nxt;
  logic [WIDTH-1:0] r_tx_sh, w_tx_sh_nxt;
  logic [WIDTH-1:0] r_rx_data, w_rx_data_nxt;
  logic             r_rx_valid, w_rx_valid_nxt;
  logic             r_frame_err, w_frame_err_nxt;
  logic             r_overrun, w_overrun_nxt;
  logic [WIDTH-1:0] w_load;
  logic [WIDTH-1:0] w_rx_shifted;
  logic [WIDTH-1:0] w_tx_shifted;

`ifdef DAC_SPI_RESPONDER_LOOPBACK_EN
  assign w_load = r_rx_data;
`else
  assign w_load = tx_data;
`endif

  assign w_rx_shifted = {r_rx_sh[WIDTH-2:0], dac_mosi};
  assign w_tx_shifted = {r_tx_sh[WIDTH-2:0], 1'b0};

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_rx_sh_nxt     = r_rx_sh;
    w_tx_sh_nxt     = r_tx_sh;
    w_rx_data_nxt   = r_rx_data;
    w_rx_valid_nxt  = 1'b0;
    w_frame_err_nxt = 1'b0;
    w_overrun_nxt   = r_overrun;
    unique case (r_state)
      ST_IDLE: begin
        if (dac_cs) begin
          w_tx_sh_nxt = w_load;
        end else begin
          w_rx_sh_nxt = w_rx_shifted;
          w_tx_sh_nxt = w_tx_shifted;
          w_cnt_nxt   = CW'(1);
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (dac_cs) begin
          // cs rising on what would be the last bit still counts as an abort
          w_frame_err_nxt = 1'b1;
          w_cnt_nxt       = '0;
          w_tx_sh_nxt     = w_load;
          w_state_nxt     = ST_IDLE;
        end else begin
          w_rx_sh_nxt = w_rx_shifted;
          w_tx_sh_nxt = w_tx_shifted;
          w_cnt_nxt   = r_cnt + CW'(1);
          if (r_cnt == LAST_BIT) begin
            w_rx_data_nxt  = w_rx_shifted;
            w_rx_valid_nxt = 1'b1;
            w_cnt_nxt      = FULL_CNT;
            w_state_nxt    = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (dac_cs) begin
          w_overrun_nxt = 1'b0;
          w_cnt_nxt     = '0;
          w_tx_sh_nxt   = w_load;
          w_state_nxt   = ST_IDLE;
        end else begin
          w_overrun_nxt = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sclk) begin
    if (!n_reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_rx_sh     <= '0;
      r_tx_sh     <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_rx_sh     <= w_rx_sh_nxt;
      r_tx_sh     <= w_tx_sh_nxt;
      r_rx_data   <= w_rx_data_nxt;
      r_rx_valid  <= w_rx_valid_nxt;
      r_frame_err <= w_frame_err_nxt;
      r_overrun   <= w_overrun_nxt;
    end
  end

  assign dac_miso    = (!dac_cs && (r_state != ST_HOLD)) ? r_tx_sh[WIDTH-1] : 1'b0;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign frame_err   = r_frame_err;
  assign overrun     = r_overrun;
  assign busy        = (r_state != ST_IDLE);
  assign o_dbg_state = r_state;

endmodule
